aes_inv_engine: RTL

AES_INV_ENGINE -- requirements
Module: aes_inv_engine

---
 rtl/aes_pkg.sv | 68 ++++++
 rtl/aes_inv_round.sv | 39 +++
 rtl/aes_inv_engine.sv | 121 ++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES-128 shared constants, S-box tables, FSM states and GF(2^8) helpers
package aes_pkg;

  localparam int NR      = 10;
  localparam int BLOCK_W = 128;
  localparam int KEY_W   = 128;

  typedef enum logic [2:0] {IDLE, EXPAND, INIT, ROUND, DONE} state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
    8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
    8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
    8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
    8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
    8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
    8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
    8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
    8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
    8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
    8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
    8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
    8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
    8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
    8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
    8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d
  };

  localparam logic [7:0] RCON [10] = '{
    8'h01,8'h02,8'h04,8'h08,8'h10,8'h20,8'h40,8'h80,8'h1b,8'h36
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// rtl/aes_inv_round.sv - one combinational AES inverse round (InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns)
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [BLOCK_W-1:0] state_in,
  input  logic [KEY_W-1:0]   round_key,
  input  logic               last_round,
  output logic [BLOCK_W-1:0] state_out
);

  logic [7:0] a [16];
  logic [7:0] s [16];

  always_comb begin
    for (int i = 0; i < 16; i++) a[i] = state_in[127-8*i -: 8];
    // byte 4c+r is row r of column c; row r rotates right by r
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        s[4*c+r] = INV_SBOX[a[4*((c-r+4)%4)+r]] ^ round_key[127-8*(4*c+r) -: 8];
      end
    end
    state_out = '0;
    for (int c = 0; c < 4; c++) begin
      if (last_round) begin
        for (int r = 0; r < 4; r++) state_out[127-8*(4*c+r) -: 8] = s[4*c+r];
      end else begin
        state_out[127-32*c -: 8] = gmul(s[4*c], 8'h0e) ^ gmul(s[4*c+1], 8'h0b) ^
                                   gmul(s[4*c+2], 8'h0d) ^ gmul(s[4*c+3], 8'h09);
        state_out[119-32*c -: 8] = gmul(s[4*c], 8'h09) ^ gmul(s[4*c+1], 8'h0e) ^
                                   gmul(s[4*c+2], 8'h0b) ^ gmul(s[4*c+3], 8'h0d);
        state_out[111-32*c -: 8] = gmul(s[4*c], 8'h0d) ^ gmul(s[4*c+1], 8'h09) ^
                                   gmul(s[4*c+2], 8'h0e) ^ gmul(s[4*c+3], 8'h0b);
        state_out[103-32*c -: 8] = gmul(s[4*c], 8'h0b) ^ gmul(s[4*c+1], 8'h0d) ^
                                   gmul(s[4*c+2], 8'h09) ^ gmul(s[4*c+3], 8'h0e);
      end
    end
  end

endmodule

// File: rtl/aes_inv_engine.sv
// rtl/aes_inv_engine.sv - iterative AES-128 decryptor; AES_INV_KEY_CACHE_EN reuses the last expanded key
module aes_inv_engine
  import aes_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [KEY_W-1:0]   anahtar,
  input  logic [BLOCK_W-1:0] blok,
  input  logic               g_gecerli,
  output logic               hazir,
  output logic [BLOCK_W-1:0] cozulmus,
  output logic               c_gecerli
);

  function automatic logic [KEY_W-1:0] next_key(input logic [KEY_W-1:0] k, input logic [7:0] rc);
    logic [31:0] t, w0, w1, w2, w3;
    t  = {SBOX[k[23:16]], SBOX[k[15:8]], SBOX[k[7:0]], SBOX[k[31:24]]} ^ {rc, 24'h0};
    w0 = k[127:96] ^ t;
    w1 = k[95:64]  ^ w0;
    w2 = k[63:32]  ^ w1;
    w3 = k[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  state_t             fsm;
  logic [3:0]         rnd;
  logic [KEY_W-1:0]   rk [NR+1];
  logic [KEY_W-1:0]   kw;
  logic [KEY_W-1:0]   nk;
  logic [BLOCK_W-1:0] blk;
  logic [BLOCK_W-1:0] st;
  logic [BLOCK_W-1:0] nxt;
`ifdef AES_INV_KEY_CACHE_EN
  logic               cache_vld;
`endif

  assign nk = next_key(kw, RCON[rnd - 4'd1]);

  aes_inv_round u_round (
    .state_in   (st),
    .round_key  (rk[rnd]),
    .last_round (rnd == 4'd0),
    .state_out  (nxt)
  );

  // rk[0] doubles as the cached key: it always holds the key of the last expansion
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm       <= IDLE;
      hazir     <= 1'b1;
      c_gecerli <= 1'b0;
      cozulmus  <= '0;
      rnd       <= '0;
`ifdef AES_INV_KEY_CACHE_EN
      cache_vld <= 1'b0;
`endif
    end else begin
      case (fsm)
        IDLE: begin
          if (g_gecerli) begin
            blk   <= blok;
            hazir <= 1'b0;
`ifdef AES_INV_KEY_CACHE_EN
            if (cache_vld && anahtar == rk[0]) begin
              fsm <= INIT;
            end else begin
              cache_vld <= 1'b0;
              rk[0]     <= anahtar;
              kw        <= anahtar;
              rnd       <= 4'd1;
              fsm       <= EXPAND;
            end
`else
            rk[0] <= anahtar;
            kw    <= anahtar;
            rnd   <= 4'd1;
            fsm   <= EXPAND;
`endif
          end
        end
        EXPAND: begin
          rk[rnd] <= nk;
          kw      <= nk;
          if (rnd == 4'(NR)) begin
            fsm <= INIT;
`ifdef AES_INV_KEY_CACHE_EN
            cache_vld <= 1'b1;
`endif
          end else begin
            rnd <= rnd + 4'd1;
          end
        end
        INIT: begin
          st  <= blk ^ rk[NR];
          rnd <= 4'(NR - 1);
          fsm <= ROUND;
        end
        ROUND: begin
          st <= nxt;
          if (rnd == 4'd0) begin
            cozulmus  <= nxt;
            c_gecerli <= 1'b1;
            fsm       <= DONE;
          end else begin
            rnd <= rnd - 4'd1;
          end
        end
        DONE: begin
          c_gecerli <= 1'b0;
          hazir     <= 1'b1;
          fsm       <= IDLE;
        end
        default: begin
          fsm   <= IDLE;
          hazir <= 1'b1;
        end
      endcase
    end
  end

endmodule
